button_events: RTL and testbench
================================

# button_events

Per-button event decoder between the button debouncer and the watch top level. It converts debounced button levels into single-cycle event pulses: press, short release, long press and auto-repeat. The top level consumes these pulses for mode stepping (btn3), start/stop versus long-hold reset (btn0), and held-increment of alarm/setup/countdown fields (btn1/btn2). This replaces ad-hoc edge and hold counters in the top level with one verified block.

## Interface
- N_BTN, 4, number of buttons; all per-button logic is replicated per bit.
- LONG_CYCLES, 250000000, hold length in cycles that qualifies as a long press (2.5 s at 100 MHz); legal range 2..2^CNT_W-1.
- REPEAT_DELAY, 50000000, hold length in cycles at which the first auto-repeat pulse fires; must be at least 1.
- REPEAT_PERIOD, 20000000, cycles between later repeat pulses; must be at least 1.
- REPEAT_EN, 4'b0110, per-button auto-repeat enable mask.
- CNT_W, 31, width of the hold counters.
- clk  in  1  system clock; this is the only clock.
- reset  in  1  synchronous, active-high reset.
- btn_db  in  N_BTN  debounced button levels, high = pressed, synchronous to clk.
- press  out  N_BTN  1-cycle pulse on the press edge.
- short_press  out  N_BTN  1-cycle pulse on release when the hold was shorter than LONG_CYCLES.
- long_press  out  N_BTN  1-cycle pulse when the hold reaches LONG_CYCLES.
- repeat  out  N_BTN  1-cycle auto-repeat pulses while held; always 0 for bits where REPEAT_EN is 0.
- held  out  N_BTN  level, high while the button is in the HELD or LONG state.

## Operation
- Each button has its own FSM with states LOCK, IDLE, HELD and LONG, a hold counter `d` (CNT_W bits, saturating) and a repeat counter `r` (CNT_W bits).
- `d` is the number of consecutive cycles that btn_db has been sampled high in the current hold; the first high sample gives d = 1.
- LOCK:
  - This is the reset state.
  - A low sample moves to IDLE. A high sample stays in LOCK.
  - A button held through reset therefore produces no events until it has been released.
- IDLE:
  - A high sample moves to HELD, sets d = 1 and pulses press.
- HELD:
  - A high sample increments d.
  - When d reaches LONG_CYCLES, move to LONG and pulse long_press.
  - A low sample moves to IDLE and pulses short_press; d clears.
- LONG:
  - d saturates at LONG_CYCLES and never wraps.
  - A low sample moves to IDLE with no pulse. There is no short_press after a long press.
- Auto-repeat, active in HELD and LONG for REPEAT_EN bits only:
  - repeat pulses at d = REPEAT_DELAY + k*REPEAT_PERIOD, for k = 0, 1, 2, ...
  - It is driven by `r`, which counts independently of the saturation of d, so repeat continues after the long press.
  - Release stops repeat immediately.
- Simultaneous events:
  - If REPEAT_DELAY = LONG_CYCLES, both long_press and repeat pulse in the same cycle.
  - Buttons are fully independent; any combination of bits may pulse in the same cycle.
- A single-cycle low between highs counts as a release followed by a new press. Glitch filtering is the debouncer's job.
- Outputs are registered, and every pulse is exactly 1 cycle wide.

## Timing
- Reset applied on edge k: from cycle k+1 all outputs are 0, all FSMs are in LOCK, and d and r are 0.
- Reset mid-hold: the hold is abandoned with no pulse. Reset has priority over all btn_db activity in the same cycle.
- Latency is 1 cycle. A btn_db change sampled at edge k appears on the outputs after edge k, i.e. during cycle k+1.
  - The press pulse appears in the cycle after the first high sample.
  - held rises together with press and falls together with short_press, or in the cycle after release from LONG.
- long_press rises in the cycle after the sample where d becomes LONG_CYCLES.
- There is no handshake. Consumers must treat the pulses as edge events and sample them every cycle.

## Test plan
All scenarios use LONG_CYCLES=10, REPEAT_DELAY=4, REPEAT_PERIOD=3 and REPEAT_EN=4'b0110.

1. Reset, then btn_db[3] high for 5 cycles, then low:
   - press[3] pulses the cycle after the rise.
   - short_press[3] pulses the cycle after the fall.
   - long_press[3] stays 0, and repeat[3] stays 0 because bit 3 is masked.
2. btn_db[0] high for 15 cycles, then low:
   - long_press[0] pulses once, in the cycle after the 10th high sample.
   - There is no short_press[0] on release.
   - held[0] is high for 15 cycles.
3. btn_db[1] high for 14 cycles:
   - repeat[1] pulses after the samples where d = 4, 7, 10 and 13.
   - long_press[1] also pulses after d = 10.
   - All pulses stop after release.
4. btn_db[2] high while reset is asserted, reset released, button held 20 more cycles, then released and pressed again:
   - Zero events during the first hold.
   - A normal press[2] pulse on the second press.
5. Reset asserted at d = 7 during a hold of button 1:
   - All outputs are 0 from the next cycle.
   - No short_press is generated.
   - The button is in LOCK until it is released.
6. btn_db = 4'b1111 for 1 cycle, then 0:
   - press = 4'b1111 for one cycle, followed by short_press = 4'b1111 for one cycle.

Source files
------------

// File: rtl/button_events.sv
// Per-button event decoder: turns debounced button levels into single-cycle
// press, short-release, long-press and auto-repeat pulses plus a held level.
//
// state  | meaning
// S_LOCK | after reset; waits for the button to be seen released
// S_IDLE | released, waiting for a press
// S_HELD | pressed, hold shorter than LONG_CYCLES
// S_LONG | pressed, long press already reported
module button_events #(
  parameter int                N_BTN         = 4,
  parameter int                LONG_CYCLES   = 250000000,
  parameter int                REPEAT_DELAY  = 50000000,
  parameter int                REPEAT_PERIOD = 20000000,
  parameter logic [N_BTN-1:0]  REPEAT_EN     = 4'b0110,
  parameter int                CNT_W         = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press,
  output logic [N_BTN-1:0] short_press,
  output logic [N_BTN-1:0] long_press,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] held
);

  typedef enum logic [1:0] {
    S_LOCK = 2'd0,
    S_IDLE = 2'd1,
    S_HELD = 2'd2,
    S_LONG = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] LONG_C  = CNT_W'(LONG_CYCLES);
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    state_t           state_q, state_d;
    logic [CNT_W-1:0] d_q, d_d;
    logic [CNT_W-1:0] r_q, r_d;
    logic             press_q, press_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             rpt_q, rpt_d;
    logic             r_hit;
    logic [CNT_W-1:0] r_tick;

    // r counts down the samples left until the next repeat; 1 means "fire now"
    assign r_hit  = (r_q == ONE);
    assign r_tick = r_hit ? RPT_PER : r_q - ONE;

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= S_LOCK;
        d_q     <= '0;
        r_q     <= '0;
        press_q <= 1'b0;
        short_q <= 1'b0;
        long_q  <= 1'b0;
        rpt_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        d_q     <= d_d;
        r_q     <= r_d;
        press_q <= press_d;
        short_q <= short_d;
        long_q  <= long_d;
        rpt_q   <= rpt_d;
      end
    end

    always_comb begin
      state_d = state_q;
      d_d     = d_q;
      r_d     = r_q;
      press_d = 1'b0;
      short_d = 1'b0;
      long_d  = 1'b0;
      rpt_d   = 1'b0;
      case (state_q)
        S_LOCK: begin
          if (!btn_db[i]) state_d = S_IDLE;
        end
        S_IDLE: begin
          if (btn_db[i]) begin
            state_d = S_HELD;
            d_d     = ONE;
            press_d = 1'b1;
            if (RPT_DLY == ONE) begin
              rpt_d = REPEAT_EN[i];
              r_d   = RPT_PER;
            end else begin
              r_d   = RPT_DLY - ONE;
            end
          end
        end
        S_HELD: begin
          if (btn_db[i]) begin
            d_d   = d_q + ONE;
            r_d   = r_tick;
            rpt_d = REPEAT_EN[i] & r_hit;
            if (d_d == LONG_C) begin
              state_d = S_LONG;
              long_d  = 1'b1;
            end
          end else begin
            state_d = S_IDLE;
            short_d = 1'b1;
            d_d     = '0;
            r_d     = '0;
          end
        end
        S_LONG: begin
          if (btn_db[i]) begin
            d_d   = LONG_C;
            r_d   = r_tick;
            rpt_d = REPEAT_EN[i] & r_hit;
          end else begin
            state_d = S_IDLE;
            d_d     = '0;
            r_d     = '0;
          end
        end
        default: state_d = S_LOCK;
      endcase
    end

    assign press[i]        = press_q;
    assign short_press[i]  = short_q;
    assign long_press[i]   = long_q;
    assign repeat_pulse[i] = rpt_q;
    assign held[i]         = (state_q == S_HELD) || (state_q == S_LONG);
  end

endmodule

// File: tb/tb_button_events.sv
// Self-checking bench for button_events: directed scenarios plus random
// button activity, all compared against a hold-length based reference model.
module tb_button_events;
  localparam int        LONG = 10;
  localparam int        DLY  = 4;
  localparam int        PER  = 3;
  localparam logic [3:0] EN  = 4'b0110;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_db = 4'b0000;
  logic [3:0] press, short_press, long_press, repeat_pulse, held;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  bit         m_lock [4];
  int         m_cnt  [4];
  logic [19:0] exp_v;
  logic [19:0] obs;

  assign obs = {press, short_press, long_press, repeat_pulse, held};

  button_events #(
    .N_BTN(4), .LONG_CYCLES(LONG), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER),
    .REPEAT_EN(EN), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(reset), .btn_db(btn_db),
    .press(press), .short_press(short_press), .long_press(long_press),
    .repeat_pulse(repeat_pulse), .held(held)
  );

  always #5 clk = ~clk;

  // Reference: events derived from the running hold length of each button.
  task automatic model_update(input logic [3:0] b, input logic r);
    logic [3:0] p, s, l, rp, h;
    p = '0; s = '0; l = '0; rp = '0; h = '0;
    for (int i = 0; i < 4; i++) begin
      if (r) begin
        m_lock[i] = 1'b1;
        m_cnt[i]  = 0;
      end else if (m_lock[i]) begin
        if (!b[i]) m_lock[i] = 1'b0;
      end else if (b[i]) begin
        m_cnt[i]++;
        h[i] = 1'b1;
        if (m_cnt[i] == 1) p[i] = 1'b1;
        if (m_cnt[i] == LONG) l[i] = 1'b1;
        if (EN[i] && m_cnt[i] >= DLY && (m_cnt[i] - DLY) % PER == 0) rp[i] = 1'b1;
      end else begin
        if (m_cnt[i] > 0 && m_cnt[i] < LONG) s[i] = 1'b1;
        m_cnt[i] = 0;
      end
    end
    exp_v = {p, s, l, rp, h};
  endtask

  task automatic step(input logic [3:0] b, input logic r);
    @(negedge clk);
    btn_db = b;
    reset  = r;
    @(posedge clk);
    cyc++;
    model_update(b, r);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b1);
      n_cmp++;
      if (obs !== 20'h0 || obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got %h want %h", cyc, obs, exp_v);
      end
    end
    for (int k = 0; k < 2; k++) begin
      step(4'b0000, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL reset_idle cyc=%0d got %h want %h", cyc, obs, exp_v);
      end
    end
  endtask

  task automatic test_short();
    for (int k = 0; k < 9; k++) begin
      step((k < 5) ? 4'b1000 : 4'b0000, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL short k=%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_long();
    int n_held = 0;
    int n_long = 0;
    for (int k = 0; k < 19; k++) begin
      step((k < 15) ? 4'b0001 : 4'b0000, 1'b0);
      n_held += held[0];
      n_long += long_press[0];
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL long k=%0d got %h want %h", k, obs, exp_v);
      end
    end
    n_cmp++;
    if (n_held != 15 || n_long != 1) begin
      n_fail++;
      $display("FAIL long_counts got held=%0d long=%0d want held=15 long=1", n_held, n_long);
    end
  endtask

  task automatic test_repeat();
    int n_rpt  = 0;
    int n_long = 0;
    for (int k = 0; k < 18; k++) begin
      step((k < 14) ? 4'b0010 : 4'b0000, 1'b0);
      n_rpt  += repeat_pulse[1];
      n_long += long_press[1];
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL repeat k=%0d got %h want %h", k, obs, exp_v);
      end
    end
    n_cmp++;
    if (n_rpt != 4 || n_long != 1) begin
      n_fail++;
      $display("FAIL repeat_counts got rpt=%0d long=%0d want rpt=4 long=1", n_rpt, n_long);
    end
  endtask

  task automatic test_lock();
    logic [3:0] b;
    logic       r;
    for (int k = 0; k < 30; k++) begin
      r = (k < 2);
      b = (k < 22 || (k >= 24 && k < 27)) ? 4'b0100 : 4'b0000;
      step(b, r);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL lock k=%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] b;
    for (int k = 0; k < 20; k++) begin
      b = (k < 12 || (k >= 14 && k < 16)) ? 4'b0010 : 4'b0000;
      step(b, k == 7);
      n_cmp++;
      if (obs !== exp_v || (k == 7 && obs !== 20'h0)) begin
        n_fail++;
        $display("FAIL reset_mid k=%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      step((k == 0) ? 4'b1111 : 4'b0000, 1'b0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL all_buttons k=%0d got %h want %h", k, obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    logic [3:0] b = 4'b0000;
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
      step(b, $urandom_range(0, 99) == 0);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL random k=%0d btn=%b got %h want %h", k, b, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_short();
    test_long();
    test_repeat();
    test_lock();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
